// File: rtl/segasys1_vid_pkg.sv
// ---------------------------------------------------------------------------
// segasys1_vid_pkg
// Shared definitions for the System 1 video tile-fetch path.
//   AW / DW        : tile ROM address / data widths (data = 3 bitplanes x 8)
//   REQ_*          : fixed requester slots on the shared tile ROM port
//   tag_t          : return tag that travels alongside an in-flight ROM read
//   next_ptr()     : round-robin pointer advance with wrap
// ---------------------------------------------------------------------------
package segasys1_vid_pkg;

    localparam int AW = 14;
    localparam int DW = 24;

    localparam logic [1:0] REQ_BG0 = 2'd0;
    localparam logic [1:0] REQ_BG1 = 2'd1;
    localparam logic [1:0] REQ_SPR = 2'd2;

    typedef struct packed {
        logic       v;
        logic [1:0] id;
    } tag_t;

    localparam tag_t TAG_NONE = '{v: 1'b0, id: 2'd0};

    // Slot after idx, wrapping to 0 after the last populated requester.
    function automatic logic [1:0] next_ptr(input logic [1:0] idx, input int nreq);
        if (int'(idx) + 1 >= nreq) begin
            return 2'd0;
        end
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/segasys1_rr_pick.sv
// ---------------------------------------------------------------------------
// segasys1_rr_pick
// Combinational round-robin priority picker: returns the first eligible
// index at or after ptr_i, searching upward modulo NREQ.
//   elig_i  : per-requester eligibility mask
//   ptr_i   : search start (always < NREQ)
//   valid_o : at least one requester eligible
//   idx_o   : chosen requester index (0 when valid_o is low)
// ---------------------------------------------------------------------------
module segasys1_rr_pick #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] elig_i,
    input  logic [1:0]      ptr_i,
    output logic            valid_o,
    output logic [1:0]      idx_o
);
    import segasys1_vid_pkg::*;

    logic [NREQ-1:0] rot;
    logic [1:0]      off;
    logic [2:0]      sum;

    always_comb begin
        // Rotate so bit 0 is the requester at ptr; the doubled vector makes
        // the rotation a plain right shift.
        rot     = NREQ'({elig_i, elig_i} >> ptr_i);
        valid_o = 1'b0;
        off     = 2'd0;
        // Walk downward so the smallest offset is the one left standing.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                valid_o = 1'b1;
                off     = 2'(i);
            end
        end
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= 3'(NREQ)) begin
            sum = sum - 3'(NREQ);
        end
        idx_o = valid_o ? sum[1:0] : 2'd0;
    end

endmodule

// File: rtl/segasys1_tile_fetch_arb.sv
// ---------------------------------------------------------------------------
// segasys1_tile_fetch_arb
// Round-robin request/grant arbiter sharing the single tile character ROM
// port among BG0, BG1 and an optional sprite/debug fetch. Each grant pushes
// an ID tag down a LAT+1 deep pipe; when the tag emerges the ROM word is
// latched into that requester's return slice and a one-cycle rdy is raised.
//   VCLKx8  : pixel x8 clock, all state on rising edge
//   RESET_N : synchronous active-low reset
//   req     : per-requester fetch request (level)
//   req_ad  : per-requester address, slice i = [i*AW +: AW]
//   gnt     : registered one-hot grant pulse
//   rdy     : registered one-hot data-valid pulse
//   rd_dt   : per-requester returned data, slice i = [i*DW +: DW]
//   rom_ad  : registered tile ROM address
//   rom_dt  : tile ROM read data
//   hold    : ROM download in progress, blocks new grants
// ---------------------------------------------------------------------------
module segasys1_tile_fetch_arb #(
    parameter int NREQ = 3,
    parameter int AW   = segasys1_vid_pkg::AW,
    parameter int DW   = segasys1_vid_pkg::DW,
    parameter int LAT  = 1
) (
    input  logic               VCLKx8,
    input  logic               RESET_N,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_ad,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rdy,
    output logic [NREQ*DW-1:0] rd_dt,
    output logic [AW-1:0]      rom_ad,
    input  logic [DW-1:0]      rom_dt,
    input  logic               hold
);
    import segasys1_vid_pkg::*;

    // ---------------- state ----------------
    logic [1:0]      ptr_q,    ptr_d;
    logic [NREQ-1:0] gnt_q,    gnt_d;
    logic [NREQ-1:0] rdy_q,    rdy_d;
    logic [AW-1:0]   rom_ad_q, rom_ad_d;
    tag_t            tag_d;
    tag_t            tag_q   [LAT+1];
    logic [DW-1:0]   rd_dt_q [NREQ];

    // ---------------- arbitration ----------------
    logic [NREQ-1:0] elig;
    logic            pick_v;
    logic [1:0]      pick_idx;
    tag_t            tag_out;

    // A requester granted this cycle is masked: its req is still high while
    // it reacts to gnt, so without the mask it would be granted twice.
    assign elig = req & ~gnt_q & {NREQ{~hold}};

    segasys1_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .elig_i  (elig),
        .ptr_i   (ptr_q),
        .valid_o (pick_v),
        .idx_o   (pick_idx)
    );

    assign tag_out = tag_q[LAT];

    always_comb begin
        ptr_d    = ptr_q;
        gnt_d    = '0;
        rom_ad_d = rom_ad_q;
        tag_d    = TAG_NONE;
        if (pick_v) begin
            ptr_d    = next_ptr(pick_idx, NREQ);
            gnt_d    = NREQ'(1) << pick_idx;
            rom_ad_d = req_ad[int'(pick_idx)*AW +: AW];
            tag_d    = '{v: 1'b1, id: pick_idx};
        end
        rdy_d = tag_out.v ? (NREQ'(1) << tag_out.id) : '0;
    end

    always_ff @(posedge VCLKx8) begin
        if (!RESET_N) begin
            ptr_q    <= '0;
            gnt_q    <= '0;
            rdy_q    <= '0;
            rom_ad_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            rdy_q    <= rdy_d;
            rom_ad_q <= rom_ad_d;
        end
    end

    // ---------------- tag pipe ----------------
    // Stage 0 loads at the granting edge; the ROM sees the address one edge
    // later and its data is ready LAT edges after that, which is exactly when
    // the tag reaches stage LAT and is consumed.
    always_ff @(posedge VCLKx8) begin
        if (!RESET_N) begin
            for (int s = 0; s <= LAT; s++) begin
                tag_q[s] <= TAG_NONE;
            end
        end else begin
            tag_q[0] <= tag_d;
            for (int s = 1; s <= LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    // ---------------- return registers ----------------
    // Each slice only changes in the cycle its own rdy goes high.
    always_ff @(posedge VCLKx8) begin
        if (!RESET_N) begin
            for (int k = 0; k < NREQ; k++) begin
                rd_dt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (tag_out.v && (tag_out.id == 2'(k))) begin
                    rd_dt_q[k] <= rom_dt;
                end
            end
        end
    end

    // ---------------- outputs ----------------
    assign gnt    = gnt_q;
    assign rdy    = rdy_q;
    assign rom_ad = rom_ad_q;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rd_dt
            assign rd_dt[gi*DW +: DW] = rd_dt_q[gi];
        end
    endgenerate

endmodule
